// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Pointer advance wraps at the channel count, not at a power of two.
    function automatic int next_ptr(input int idx, input int num_ch);
        return (idx == num_ch - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    int k;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        k         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            if (!gnt_valid && req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream multiplexer with fixed or round-robin channel selection
// onto a single registered valid/ready output.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] din,
    input  logic [NUM_CH-1:0]        din_valid,
    output logic [NUM_CH-1:0]        din_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         select,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [SEL_W-1:0]         dout_ch
);

    logic              load_en;
    logic              rr_valid;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  ptr;
    logic              gnt_valid;
    logic [SEL_W-1:0]  gnt_idx;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req      (din_valid),
        .ptr      (ptr),
        .gnt_valid(rr_valid),
        .gnt_idx  (rr_idx)
    );

    assign load_en = ~dout_valid | dout_ready;

    // Out-of-range fixed selects (non power-of-two NUM_CH) grant nothing.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = int'(select) < NUM_CH;
            gnt_idx   = select;
        end
    end

    always_comb begin
        din_ready = '0;
        if (gnt_valid && load_en) din_ready[gnt_idx] = 1'b1;
    end

    assign xfer     = |(din_valid & din_ready);
    assign sel_data = din[int'(gnt_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
            ptr        <= '0;
        end else begin
            if (xfer) begin
                dout       <= sel_data;
                dout_ch    <= gnt_idx;
                dout_valid <= 1'b1;
                if (mode == MODE_RR)
                    ptr <= SEL_W'(next_ptr(int'(gnt_idx), NUM_CH));
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: 4-channel and 3-channel builds.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] d4;
    logic [3:0]  v4, rdy4;
    logic        m4, r4, ov4;
    logic [1:0]  s4, ch4;
    logic [7:0]  o4;

    logic [23:0] d3;
    logic [2:0]  v3, rdy3;
    logic        m3, r3, ov3;
    logic [1:0]  s3, ch3;
    logic [7:0]  o3;

    int checks = 0;
    int errors = 0;

    rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) u4 (
        .clk(clk), .rst(rst), .din(d4), .din_valid(v4), .din_ready(rdy4),
        .mode(m4), .select(s4), .dout(o4), .dout_valid(ov4),
        .dout_ready(r4), .dout_ch(ch4)
    );

    rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) u3 (
        .clk(clk), .rst(rst), .din(d3), .din_valid(v3), .din_ready(rdy3),
        .mode(m3), .select(s3), .dout(o3), .dout_valid(ov3),
        .dout_ready(r3), .dout_ch(ch3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d4 = '0; v4 = '0; m4 = 1'b0; s4 = '0; r4 = 1'b1;
        d3 = '0; v3 = '0; m3 = 1'b0; s3 = '0; r3 = 1'b1;
        #1;
        check("rst_dout", o4, 0);
        check("rst_valid", ov4, 0);
        check("rst_ch", ch4, 0);
        #12 rst = 1'b0;
        step();

        // fixed mode, select=2
        s4 = 2'd2; d4[2*8 +: 8] = 8'hA5; v4 = 4'b0100;
        #1 check("fix_rdy2", rdy4, 4'b0100);
        step();
        check("fix_dout", o4, 8'hA5);
        check("fix_ch", ch4, 2);
        check("fix_valid", ov4, 1);

        // fixed mode, select=1 while only ch2 valid
        s4 = 2'd1;
        #1 check("fix_rdy1", rdy4, 4'b0010);
        step();
        check("fix_novalid", ov4, 0);
        check("fix_hold", o4, 8'hA5);

        // round-robin fairness, all valid
        m4 = 1'b1; v4 = 4'b1111;
        for (int k = 0; k < 4; k++) d4[k*8 +: 8] = 8'(8'h10 + k);
        #1 check("rr_rdy0", rdy4, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rr_ch%0d", i), ch4, i % 4);
            check($sformatf("rr_d%0d", i), o4, 8'h10 + (i % 4));
            check($sformatf("rr_v%0d", i), ov4, 1);
        end

        // ptr=2: ch2 moves ptr to 3
        v4 = 4'b0100;
        step();
        check("sk_ch2", ch4, 2);
        v4 = 4'b0010;
        #1 check("sk_rdy1", rdy4, 4'b0010);
        step();
        check("sk_ch1", ch4, 1);
        v4 = 4'b1001;
        #1 check("wr_rdy3", rdy4, 4'b1000);
        step();
        check("wr_ch3", ch4, 3);
        v4 = 4'b1111;
        #1 check("wr_rdy0", rdy4, 4'b0001);
        step();
        check("wr_ch0", ch4, 0);
        check("wr_d0", o4, 8'h10);

        // backpressure for 5 cycles
        r4 = 1'b0;
        d4[1*8 +: 8] = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("bp_rdy%0d", i), rdy4, 0);
            step();
            check($sformatf("bp_d%0d", i), o4, 8'h10);
            check($sformatf("bp_ch%0d", i), ch4, 0);
            check($sformatf("bp_v%0d", i), ov4, 1);
        end
        r4 = 1'b1;
        #1 check("bp_rel_rdy", rdy4, 4'b0010);
        step();
        check("bp_rel_d", o4, 8'h5A);
        check("bp_rel_ch", ch4, 1);
        check("bp_rel_v", ov4, 1);

        // asynchronous reset with a word held
        #2 rst = 1'b1;
        #1;
        check("arst_v", ov4, 0);
        check("arst_d", o4, 0);
        check("arst_ch", ch4, 0);
        #2 rst = 1'b0;
        #1 check("arst_rdy", rdy4, 4'b0001);
        step();
        check("arst_ch0", ch4, 0);
        check("arst_v1", ov4, 1);
        v4 = '0;

        // 3-channel build: out-of-range select
        s3 = 2'd3; v3 = 3'b111;
        d3 = {8'h33, 8'h22, 8'h11};
        #1 check("n3_rdy_oor", rdy3, 3'b000);
        step();
        check("n3_noxfer", ov3, 0);

        // 3-channel round-robin wrap after ch2
        m3 = 1'b1; v3 = 3'b100;
        #1 check("n3_rdy2", rdy3, 3'b100);
        step();
        check("n3_ch2", ch3, 2);
        check("n3_d2", o3, 8'h33);
        v3 = 3'b111;
        #1 check("n3_wrap", rdy3, 3'b001);
        step();
        check("n3_ch0", ch3, 0);
        check("n3_d0", o3, 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
